// File: rtl/osc_clock_divider.sv
// osc_clock_divider: phase-accumulator divider for the 48 MHz oscillator.
// It produces a one-cycle tick at each accumulator wrap and a ~50% duty
// clock-enable (the registered accumulator MSB). A stop request is honoured
// only at a wrap, so the output period never truncates.
// Optional feature macro: OSC_CLKDIV_RUNTIME_EN adds a valid/ready increment
// load port. The new increment takes effect at the next wrap, or at once when
// the divider is stopped.
module osc_clock_divider #(
    parameter int unsigned FREQ_IN  = 48000000,
    parameter int unsigned FREQ_OUT = 1000000,
    parameter int unsigned ACC_W    = 32
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             en,
`ifdef OSC_CLKDIV_RUNTIME_EN
    input  logic [ACC_W-1:0] inc_data,
    input  logic             inc_valid,
    output logic             inc_ready,
`endif
    output logic             tick,
    output logic             clkout,
    output logic             running
);

    // Reset-time increment, rounded to nearest.
    localparam logic [63:0] INC0_64 =
        ((64'(FREQ_OUT) << ACC_W) + 64'(FREQ_IN / 2)) / 64'(FREQ_IN);
    localparam logic [63:0]      HALF_64 = 64'd1 << (ACC_W - 1);
    localparam logic [ACC_W-1:0] INC0    = INC0_64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] HALF    = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};

    if (INC0_64 == 64'd0 || INC0_64 > HALF_64) begin : g_bad_inc0
        $error("osc_clock_divider: INC0 out of range for FREQ_IN/FREQ_OUT/ACC_W");
    end

    typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN} state_t;

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_inc;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_active;
    logic             w_stop;
    logic             r_tick;
    logic             r_clkout;

    assign w_sum   = {1'b0, r_acc} + {1'b0, w_inc};
    assign w_carry = w_sum[ACC_W];

    // State register.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) r_state <= S_OFF;
        else         r_state <= w_state_nxt;
    end

    // Next state; a drain completes only on the cycle that wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            S_OFF: begin
                if (en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_active = 1'b1;
                if (!en) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_active = 1'b1;
                if (en) begin
                    w_state_nxt = S_RUN;
                end else if (w_carry) begin
                    w_state_nxt = S_OFF;
                    w_stop      = 1'b1;
                end
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    // Accumulator and registered outputs; OFF parks everything at zero.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_acc    <= '0;
            r_tick   <= 1'b0;
            r_clkout <= 1'b0;
        end else if (w_active) begin
            r_tick <= w_carry;
            if (w_stop) begin
                r_acc    <= '0;
                r_clkout <= 1'b0;
            end else begin
                r_acc    <= w_sum[ACC_W-1:0];
                r_clkout <= w_sum[ACC_W-1];
            end
        end else begin
            r_acc    <= '0;
            r_tick   <= 1'b0;
            r_clkout <= 1'b0;
        end
    end

`ifdef OSC_CLKDIV_RUNTIME_EN
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_pend_inc;
    logic             r_pend;
    logic [ACC_W-1:0] w_inc_clamped;
    logic             w_load;
    logic             w_copy;

    // Out-of-range requests are pulled into [1, 2^(ACC_W-1)].
    always_comb begin
        w_inc_clamped = inc_data;
        if (inc_data == '0)       w_inc_clamped = ONE;
        else if (inc_data > HALF) w_inc_clamped = HALF;
    end

    assign w_load    = inc_valid & ~r_pend;
    assign w_copy    = r_pend & ((r_state == S_OFF) | (w_active & w_carry));
    assign inc_ready = ~r_pend;
    assign w_inc     = r_inc;

    // Pending increment: captured on handshake, applied at a wrap or while stopped.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_inc      <= INC0;
            r_pend_inc <= '0;
            r_pend     <= 1'b0;
        end else if (w_copy) begin
            r_inc  <= r_pend_inc;
            r_pend <= 1'b0;
        end else if (w_load) begin
            r_pend_inc <= w_inc_clamped;
            r_pend     <= 1'b1;
        end
    end
`else
    assign w_inc = INC0;
`endif

    assign tick    = r_tick;
    assign clkout  = r_clkout;
    assign running = (r_state != S_OFF);

endmodule

// File: tb/tb_osc_clock_divider.sv
// Bench for osc_clock_divider: directed scenarios plus a randomized run
// against an arithmetic reference model; a second instance uses the
// 48 MHz / 1 MHz / 32-bit parameter set.
module tb_osc_clock_divider;

    localparam int W     = 8;
    localparam int MOD   = 1 << W;
    localparam int HALFV = 1 << (W - 1);
    localparam int INC0  = (4 * MOD + 16 / 2) / 16;
    localparam longint unsigned MOD2  = 64'd1 << 32;
    localparam longint unsigned INC02 = ((64'd1000000 << 32) + 64'd24000000) / 64'd48000000;

    logic CLK = 1'b0;
    logic resetn = 1'b1;
    logic en = 1'b0;
    logic en2 = 1'b0;
    logic tick, clkout, running;
    logic tick2, clkout2, running2;
`ifdef OSC_CLKDIV_RUNTIME_EN
    logic [W-1:0] inc_data = '0;
    logic         inc_valid = 1'b0;
    logic         inc_ready;
    logic [31:0]  inc_data2 = '0;
    logic         inc_valid2 = 1'b0;
    logic         inc_ready2;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_acc, m_inc, m_pend_val;
    bit m_live, m_stop, m_pend, m_tick, m_clk;

    always #5 CLK = ~CLK;

    osc_clock_divider #(.FREQ_IN(16), .FREQ_OUT(4), .ACC_W(W)) dut (
        .CLK(CLK), .resetn(resetn), .en(en),
`ifdef OSC_CLKDIV_RUNTIME_EN
        .inc_data(inc_data), .inc_valid(inc_valid), .inc_ready(inc_ready),
`endif
        .tick(tick), .clkout(clkout), .running(running)
    );

    osc_clock_divider #(.FREQ_IN(48000000), .FREQ_OUT(1000000), .ACC_W(32)) dut2 (
        .CLK(CLK), .resetn(resetn), .en(en2),
`ifdef OSC_CLKDIV_RUNTIME_EN
        .inc_data(inc_data2), .inc_valid(inc_valid2), .inc_ready(inc_ready2),
`endif
        .tick(tick2), .clkout(clkout2), .running(running2)
    );

    function automatic int clamp_inc(int d);
        if (d == 0) return 1;
        if (d > HALFV) return HALFV;
        return d;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_inc = INC0; m_pend_val = 0;
        m_live = 0; m_stop = 0; m_pend = 0; m_tick = 0; m_clk = 0;
    endtask

    // One clock edge of the reference: the divider runs while "live"; a stop
    // request completes only on an add that wraps past MOD.
    task automatic model_edge();
        bit pend_in, was_off, carry;
        int s;
        if (!resetn) begin model_reset(); return; end
        pend_in = m_pend;
        was_off = !m_live;
        carry   = 0;
        if (!m_live) begin
            m_acc = 0; m_tick = 0; m_clk = 0; m_stop = 0; m_live = en;
        end else begin
            s = m_acc + m_inc;
            carry = (s >= MOD);
            s = s % MOD;
            m_tick = carry;
            if (m_stop && !en && carry) begin
                m_acc = 0; m_clk = 0; m_live = 0; m_stop = 0;
            end else begin
                m_acc = s; m_clk = (s >= HALFV); m_stop = !en;
            end
        end
`ifdef OSC_CLKDIV_RUNTIME_EN
        if (pend_in && (was_off || carry)) begin m_inc = m_pend_val; m_pend = 0; end
        if (inc_valid && !pend_in) begin m_pend = 1; m_pend_val = clamp_inc(int'(inc_data)); end
`else
        if (pend_in || was_off || carry) m_pend = 0;
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
        total++; if (clkout !== 1'b0) begin bad++; $display("FAIL reset_clkout got=%b want=0", clkout); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
`ifdef OSC_CLKDIV_RUNTIME_EN
        total++; if (inc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", inc_ready); end
`endif
        @(negedge CLK);
        en = 1'b1;
        step(); step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_hold_running got=%b want=0", running); end
        en = 1'b0;
        resetn = 1'b1;
        step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_idle_running got=%b want=0", running); end
    endtask

    // en rises: edge 0 enters RUN, adds 1.. give acc 64,128,192,0,...
    task automatic test_start();
        en = 1'b1;
        step();
        total++; if (running !== 1'b1 || tick !== 1'b0 || clkout !== 1'b0) begin
            bad++; $display("FAIL start_edge0 got=%b%b%b want=100", running, tick, clkout);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            total++; if (tick !== ((k % 4) == 0)) begin
                bad++; $display("FAIL start_tick add=%0d got=%b want=%b", k, tick, (k % 4) == 0);
            end
            total++; if (clkout !== (((k * 64) % 256) >= 128)) begin
                bad++; $display("FAIL start_clkout add=%0d got=%b want=%b", k, clkout, ((k * 64) % 256) >= 128);
            end
            total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running add=%0d got=%b want=1", k, running); end
        end
    endtask

    // en drops one cycle after acc=64: drain to the wrap, one tick, then OFF.
    task automatic test_drain();
        logic [0:5] t_exp, c_exp, r_exp;
        t_exp = 6'b001000;
        c_exp = 6'b110000;
        r_exp = 6'b110000;
        step();
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            total++; if (tick !== t_exp[k] || clkout !== c_exp[k] || running !== r_exp[k]) begin
                bad++; $display("FAIL drain cyc=%0d got=%b%b%b want=%b%b%b", k, tick, clkout, running, t_exp[k], c_exp[k], r_exp[k]);
            end
        end
    endtask

`ifdef OSC_CLKDIV_RUNTIME_EN
    task automatic test_runtime_load();
        int n;
        en = 1'b1;
        step(); step(); step();
        inc_valid = 1'b1; inc_data = 8'd32;
        step();
        inc_valid = 1'b0;
        total++; if (inc_ready !== 1'b0 || tick !== 1'b0) begin
            bad++; $display("FAIL load_ready_drop ready=%b tick=%b want ready=0 tick=0", inc_ready, tick);
        end
        step();
        total++; if (tick !== 1'b1 || inc_ready !== 1'b1) begin
            bad++; $display("FAIL load_wrap tick=%b ready=%b want 1 1", tick, inc_ready);
        end
        n = 0;
        do begin step(); n++; end while (!tick && n < 20);
        total++; if (n != 8) begin bad++; $display("FAIL load_new_period got=%0d want=8", n); end
    endtask

    task automatic test_load_on_carry();
        int n;
        n = 0;
        while ((m_acc + m_inc) < MOD && n < 20) begin step(); n++; end
        inc_valid = 1'b1; inc_data = 8'd128;
        step();
        total++; if (tick !== 1'b1 || inc_ready !== 1'b0) begin
            bad++; $display("FAIL carry_load tick=%b ready=%b want 1 0", tick, inc_ready);
        end
        inc_data = 8'd16;
        step();
        inc_valid = 1'b0;
        total++; if (inc_ready !== 1'b0) begin bad++; $display("FAIL second_load_ready got=%b want=0", inc_ready); end
        n = 0;
        do begin step(); n++; end while (!tick && n < 20);
        total++; if (n != 7) begin bad++; $display("FAIL carry_old_period got=%0d want=7", n); end
        // increment 2^(W-1): tick every 2, clkout toggles each cycle
        for (int k = 1; k <= 6; k++) begin
            step();
            total++; if (clkout !== (k % 2 == 1) || tick !== (k % 2 == 0)) begin
                bad++; $display("FAIL half_inc k=%0d got=%b%b want=%b%b", k, clkout, tick, k % 2 == 1, k % 2 == 0);
            end
        end
        inc_valid = 1'b1; inc_data = 8'd0;
        step();
        inc_valid = 1'b0;
        n = 0;
        do begin step(); n++; end while (!tick && n < 10);
        n = 0;
        do begin step(); n++; end while (!tick && n < 300);
        total++; if (n != 256) begin bad++; $display("FAIL clamp_zero_period got=%0d want=256", n); end
        inc_valid = 1'b1; inc_data = 8'd200;
        step();
        inc_valid = 1'b0;
        n = 0;
        do begin step(); n++; end while (!tick && n < 300);
        n = 0;
        do begin step(); n++; end while (!tick && n < 300);
        total++; if (n != 2) begin bad++; $display("FAIL clamp_high_period got=%0d want=2", n); end
        en = 1'b0;
        n = 0;
        do begin step(); n++; end while (running && n < 10);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL clamp_stop running=%b want=0", running); end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        en = 1'b1;
        step(); step();
`ifdef OSC_CLKDIV_RUNTIME_EN
        inc_valid = 1'b1; inc_data = 8'd32;
`endif
        step();
`ifdef OSC_CLKDIV_RUNTIME_EN
        inc_valid = 1'b0;
`endif
        total++; if (clkout !== 1'b1) begin bad++; $display("FAIL mid_pre_clkout got=%b want=1", clkout); end
        #2 resetn = 1'b0;
        #1;
        total++; if (tick !== 1'b0 || clkout !== 1'b0 || running !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%b%b%b want=000", tick, clkout, running);
        end
`ifdef OSC_CLKDIV_RUNTIME_EN
        total++; if (inc_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b want=1", inc_ready); end
`endif
        step();
        resetn = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            total++; if (tick !== (k == 4) || clkout !== (k == 2 || k == 3)) begin
                bad++; $display("FAIL mid_restart add=%0d got=%b%b want=%b%b", k, tick, clkout, k == 4, k == 2 || k == 3);
            end
        end
        en = 1'b0;
        n = 0;
        do begin step(); n++; end while (running && n < 10);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            resetn = ($urandom_range(0, 149) != 0);
`ifdef OSC_CLKDIV_RUNTIME_EN
            inc_valid = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0: inc_data = 8'd0;
                1: inc_data = 8'd255;
                2: inc_data = 8'd128;
                3: inc_data = 8'd129;
                default: inc_data = 8'($urandom_range(1, 255));
            endcase
`endif
            step();
            total++; if (tick !== m_tick || clkout !== m_clk || running !== m_live) begin
                bad++; $display("FAIL rand cyc=%0d got=%b%b%b want=%b%b%b", c, tick, clkout, running, m_tick, m_clk, m_live);
            end
`ifdef OSC_CLKDIV_RUNTIME_EN
            total++; if (inc_ready !== !m_pend) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, inc_ready, !m_pend);
            end
`endif
        end
        resetn = 1'b1;
        en = 1'b0;
`ifdef OSC_CLKDIV_RUNTIME_EN
        inc_valid = 1'b0;
`endif
    endtask

    task automatic test_hires();
        longint unsigned acc2;
        int dut_first;
        bit exp_t;
        acc2 = 0;
        dut_first = 0;
        en2 = 1'b1;
        step();
        total++; if (running2 !== 1'b1 || tick2 !== 1'b0) begin
            bad++; $display("FAIL hires_start got=%b%b want=10", running2, tick2);
        end
        for (int k = 1; k <= 200; k++) begin
            step();
            acc2 = acc2 + INC02;
            exp_t = (acc2 >= MOD2);
            if (exp_t) acc2 = acc2 - MOD2;
            if (tick2 === 1'b1 && dut_first == 0) dut_first = k;
            total++; if (tick2 !== exp_t || clkout2 !== (acc2 >= (MOD2 >> 1))) begin
                bad++; $display("FAIL hires add=%0d got=%b%b want=%b%b", k, tick2, clkout2, exp_t, acc2 >= (MOD2 >> 1));
            end
        end
        total++; if (dut_first != 49) begin bad++; $display("FAIL hires_first_tick got=%0d want=49", dut_first); end
        en2 = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_drain();
`ifdef OSC_CLKDIV_RUNTIME_EN
        test_runtime_load();
        test_load_on_carry();
`endif
        test_reset_mid();
        test_random();
        test_hires();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
